req_encoder8x3: RTL and testbench
=================================

// Module: req_encoder8x3
// PURPOSE
//   Registered 8-to-3 request encoder; inverse of the pipeline's 3x8 one-hot decoder. Same index map:
//   index i <-> vector bit (7-i), so 3'b000 <-> 8'b1000_0000 and 3'b111 <-> 8'b0000_0001.
//   Takes an 8-bit request/one-hot vector under valid/ready and returns a winning index,
//   its one-hot grant, and zero/multi-hot flags. Used for request arbitration and one-hot index recovery.
// PARAMETERS
//   ROUND_ROBIN  0  0 = fixed priority (index 0 / bit 7 highest); 1 = rotating priority via pointer ptr
// PORTS
//   clk        in   1  clock; all state updates on rising edge
//   rst        in   1  synchronous, active-high reset
//   req        in   8  request vector; bit (7-i) = request for index i
//   in_valid   in   1  req is valid this cycle
//   in_ready   out  1  block accepts req this cycle
//   idx        out  3  winning index
//   grant      out  8  one-hot of idx in decoder map (8'b1000_0000 >> idx); 8'h00 when none=1
//   none       out  1  captured req was 8'h00
//   multi      out  1  captured req had more than one bit set
//   out_valid  out  1  idx/grant/none/multi hold a result
//   out_ready  in   1  downstream takes the result this cycle
// BEHAVIOUR
//   Reset (rst=1 at edge): out_valid=0, idx=0, grant=0, none=0, multi=0, ptr=0. in_ready=0 while rst=1.
//   in_ready = !rst && (!out_valid || out_ready)  (single output register, full throughput, comb. ready).
//   Capture: in_valid && in_ready at edge -> result registered, out_valid=1 next cycle (latency 1).
//   Output: if out_valid && !out_ready, all outputs hold stable; no new req is captured.
//   Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid=0 next cycle; data regs hold.
//   Simultaneous drain and capture: new result replaces old, out_valid stays 1 (back-to-back).
//   Winner, fixed (ROUND_ROBIN=0): smallest i with req[7-i]=1.
//   Winner, round-robin: first i in ptr, ptr+1, ..., ptr+7 (mod 8) with req[7-i]=1.
//   ptr updates at capture only: nonzero req -> ptr <= (winner+1) mod 8 (7 wraps to 0); zero req -> ptr unchanged.
//   ptr is unused and stays 0 when ROUND_ROBIN=0.
//   Zero req: none=1, idx=0, grant=8'h00, multi=0; still a valid result (out_valid=1).
//   multi = popcount(req) > 1, independent of mode; idx/grant still give the winner.
//   Reset mid-operation: pending result dropped, out_valid=0 and ptr=0 next cycle, regardless of handshakes.
//   in_valid ignored (no capture, no ptr change) while in_ready=0.
//   No combinational path from req to outputs; in_ready depends only on out_valid, out_ready, rst.
// TESTING
//   1 Fixed: req=8'b1000_0000 captured -> next cycle out_valid=1, idx=0, grant=8'h80, none=0, multi=0.
//   2 Fixed: req=8'b0010_0100 -> idx=2, grant=8'h20, multi=1; req=8'h01 -> idx=7, grant=8'h01.
//   3 Zero: req=8'h00 -> none=1, idx=0, grant=8'h00, multi=0, out_valid=1; in RR mode ptr unchanged.
//   4 Backpressure: result idx=3, out_ready=0 for 5 cycles, in_valid=1 with req=8'h01 ->
//     in_ready=0, idx/grant stable; out_ready=1 -> req=8'h01 captured, idx=7 next cycle.
//   5 RR: req=8'hFF captured 4 back-to-back (out_ready=1) -> idx 0,1,2,3, one result per cycle;
//     set ptr=7 via prior win at idx 6, req=8'h81 -> idx 7, then req=8'h81 -> idx 0 (wrap).
//   6 Reset mid-transfer: out_valid=1, out_ready=0, assert rst 1 cycle -> out_valid=0, in_ready=0 during rst;
//     in RR mode, req=8'h01 then req=8'hFF after reset -> idx 7 then idx 0 (ptr cleared to 0).

Source files
------------

// File: rtl/req_encoder8x3_if.sv
// Request-in / result-out handshake bundle for req_encoder8x3.
// master drives requests and consumes results; slave is the encoder.
interface req_encoder8x3_if;
    logic [7:0] req;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] idx;
    logic [7:0] grant;
    logic       none;
    logic       multi;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output req, in_valid, out_ready,
        input  in_ready, idx, grant, none, multi, out_valid
    );

    modport slave (
        input  req, in_valid, out_ready,
        output in_ready, idx, grant, none, multi, out_valid
    );
endinterface

// File: rtl/req_encoder8x3.sv
// Registered 8-to-3 request encoder, fixed or rotating priority.
// Index i maps to vector bit (7-i); grant is 8'h80 >> idx, or 8'h00 when no request.
module req_encoder8x3 #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    req_encoder8x3_if.slave bus
);
    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready is combinational from out_valid/out_ready/rst so a single output
    // register sustains one result per cycle; the result holds while out_ready=0.
    logic       out_valid_q;
    logic [2:0] idx_q;
    logic [7:0] grant_q;
    logic       none_q;
    logic       multi_q;
    logic [2:0] ptr_q;

    logic       capture;
    logic [2:0] win;
    logic       req_any;
    logic       req_multi;
    logic [2:0] cand;

    assign bus.in_ready  = !rst && (!out_valid_q || bus.out_ready);
    assign capture       = bus.in_valid && bus.in_ready;
    assign req_any       = |bus.req;
    assign req_multi     = (bus.req & (bus.req - 8'd1)) != 8'd0;

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        win  = 3'd0;
        cand = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            cand = ROUND_ROBIN ? (ptr_q + 3'(k)) : 3'(k);
            if (bus.req[3'd7 - cand]) begin
                win = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            idx_q       <= 3'd0;
            grant_q     <= 8'h00;
            none_q      <= 1'b0;
            multi_q     <= 1'b0;
            ptr_q       <= 3'd0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            idx_q       <= win;
            grant_q     <= req_any ? (8'h80 >> win) : 8'h00;
            none_q      <= !req_any;
            multi_q     <= req_multi;
            if (ROUND_ROBIN && req_any) begin
                ptr_q <= win + 3'd1;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.idx       = idx_q;
    assign bus.grant     = grant_q;
    assign bus.none      = none_q;
    assign bus.multi     = multi_q;
endmodule

// File: tb/tb_req_encoder8x3.sv
// Directed bench for req_encoder8x3: one fixed-priority and one round-robin instance
// driven from hand-computed vectors.
module tb_req_encoder8x3;
    logic clk;
    logic rst;
    int   checks;
    int   passed;

    req_encoder8x3_if if_f ();
    req_encoder8x3_if if_r ();

    req_encoder8x3 #(.ROUND_ROBIN(1'b0)) dut_f (.clk(clk), .rst(rst), .bus(if_f.slave));
    req_encoder8x3 #(.ROUND_ROBIN(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(if_r.slave));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks; sel=0 fixed instance, sel=1 round-robin instance
    task automatic drive(input bit sel, input logic [7:0] r, input logic v, input logic ordy);
        if (sel) begin
            if_r.req = r; if_r.in_valid = v; if_r.out_ready = ordy;
        end else begin
            if_f.req = r; if_f.in_valid = v; if_f.out_ready = ordy;
        end
    endtask

    task automatic capture(input bit sel, input logic [7:0] r);
        drive(sel, r, 1'b1, 1'b1);
        tick();
        drive(sel, r, 1'b0, 1'b1);
    endtask

    task automatic expect_out(input bit sel, input string tag, input logic v,
                              input logic [2:0] i, input logic [7:0] g,
                              input logic n, input logic m);
        if (sel) begin
            check({tag, ".valid"}, 32'(if_r.out_valid), 32'(v));
            check({tag, ".idx"},   32'(if_r.idx),       32'(i));
            check({tag, ".grant"}, 32'(if_r.grant),     32'(g));
            check({tag, ".none"},  32'(if_r.none),      32'(n));
            check({tag, ".multi"}, 32'(if_r.multi),     32'(m));
        end else begin
            check({tag, ".valid"}, 32'(if_f.out_valid), 32'(v));
            check({tag, ".idx"},   32'(if_f.idx),       32'(i));
            check({tag, ".grant"}, 32'(if_f.grant),     32'(g));
            check({tag, ".none"},  32'(if_f.none),      32'(n));
            check({tag, ".multi"}, 32'(if_f.multi),     32'(m));
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst    = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        tick();
        tick();

        // reset state
        expect_out(1'b0, "rst_f", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        expect_out(1'b1, "rst_r", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        check("rst_in_ready_low", 32'(if_f.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(if_f.in_ready), 32'd1);

        // fixed priority
        capture(1'b0, 8'h80);
        expect_out(1'b0, "f_80", 1'b1, 3'd0, 8'h80, 1'b0, 1'b0);
        tick();
        check("f_drain.valid", 32'(if_f.out_valid), 32'd0);
        check("f_drain.idx_hold", 32'(if_f.idx), 32'd0);
        capture(1'b0, 8'h24);
        expect_out(1'b0, "f_24", 1'b1, 3'd2, 8'h20, 1'b0, 1'b1);
        capture(1'b0, 8'h01);
        expect_out(1'b0, "f_01", 1'b1, 3'd7, 8'h01, 1'b0, 1'b0);
        capture(1'b0, 8'h00);
        expect_out(1'b0, "f_00", 1'b1, 3'd0, 8'h00, 1'b1, 1'b0);
        capture(1'b0, 8'hFF);
        expect_out(1'b0, "f_ff_a", 1'b1, 3'd0, 8'h80, 1'b0, 1'b1);
        capture(1'b0, 8'hFF);
        expect_out(1'b0, "f_ff_b", 1'b1, 3'd0, 8'h80, 1'b0, 1'b1);

        // backpressure
        capture(1'b0, 8'h10);
        expect_out(1'b0, "f_10", 1'b1, 3'd3, 8'h10, 1'b0, 1'b0);
        drive(1'b0, 8'h01, 1'b1, 1'b0);
        #1;
        check("bp_in_ready", 32'(if_f.in_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            expect_out(1'b0, $sformatf("bp_hold%0d", c), 1'b1, 3'd3, 8'h10, 1'b0, 1'b0);
            check($sformatf("bp_ready%0d", c), 32'(if_f.in_ready), 32'd0);
        end
        drive(1'b0, 8'h01, 1'b1, 1'b1);
        #1;
        check("bp_release_ready", 32'(if_f.in_ready), 32'd1);
        tick();
        drive(1'b0, 8'h01, 1'b0, 1'b1);
        expect_out(1'b0, "bp_01", 1'b1, 3'd7, 8'h01, 1'b0, 1'b0);
        tick();
        check("bp_drain.valid", 32'(if_f.out_valid), 32'd0);
        check("bp_drain.idx_hold", 32'(if_f.idx), 32'd7);

        // round robin: ptr 0 -> 1 -> 2 -> 3 -> 4
        capture(1'b1, 8'hFF);
        expect_out(1'b1, "rr_ff0", 1'b1, 3'd0, 8'h80, 1'b0, 1'b1);
        capture(1'b1, 8'hFF);
        expect_out(1'b1, "rr_ff1", 1'b1, 3'd1, 8'h40, 1'b0, 1'b1);
        capture(1'b1, 8'hFF);
        expect_out(1'b1, "rr_ff2", 1'b1, 3'd2, 8'h20, 1'b0, 1'b1);
        capture(1'b1, 8'hFF);
        expect_out(1'b1, "rr_ff3", 1'b1, 3'd3, 8'h10, 1'b0, 1'b1);
        // zero request leaves ptr at 4
        capture(1'b1, 8'h00);
        expect_out(1'b1, "rr_00", 1'b1, 3'd0, 8'h00, 1'b1, 1'b0);
        capture(1'b1, 8'hFF);
        expect_out(1'b1, "rr_ff4", 1'b1, 3'd4, 8'h08, 1'b0, 1'b1);
        // ptr=5: win at 6 sets ptr=7, then 8'h81 wraps
        capture(1'b1, 8'h02);
        expect_out(1'b1, "rr_02", 1'b1, 3'd6, 8'h02, 1'b0, 1'b0);
        capture(1'b1, 8'h81);
        expect_out(1'b1, "rr_81a", 1'b1, 3'd7, 8'h01, 1'b0, 1'b1);
        capture(1'b1, 8'h81);
        expect_out(1'b1, "rr_81b", 1'b1, 3'd0, 8'h80, 1'b0, 1'b1);
        // ptr=1: win at 2 leaves ptr=3 before reset
        capture(1'b1, 8'h20);
        expect_out(1'b1, "rr_20", 1'b1, 3'd2, 8'h20, 1'b0, 1'b0);

        // reset mid-transfer with a held result and a pending request
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        tick();
        check("mid_hold.valid", 32'(if_r.out_valid), 32'd1);
        rst = 1'b1;
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        #1;
        check("mid_rst.in_ready", 32'(if_r.in_ready), 32'd0);
        tick();
        check("mid_rst.valid", 32'(if_r.out_valid), 32'd0);
        check("mid_rst.in_ready2", 32'(if_r.in_ready), 32'd0);
        rst = 1'b0;
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        capture(1'b1, 8'hFF);
        expect_out(1'b1, "post_rst_ff", 1'b1, 3'd0, 8'h80, 1'b0, 1'b1);
        capture(1'b1, 8'h01);
        expect_out(1'b1, "post_rst_01", 1'b1, 3'd7, 8'h01, 1'b0, 1'b0);
        capture(1'b1, 8'hFF);
        expect_out(1'b1, "post_rst_ff2", 1'b1, 3'd0, 8'h80, 1'b0, 1'b1);

        // final report
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
